// File: rtl/fp_wb_arbiter_pkg.sv
// Shared types and constants for the FP writeback arbiter.
package fp_wb_arbiter_pkg;

  localparam int unsigned FP_WB_UNITS = 3;
  localparam int unsigned FLOPOCO_W   = 34;
  localparam int unsigned FP_ID_W     = 3;

  // Index width for a vector of n entries; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned FP_WB_UNIT_W = idx_width(FP_WB_UNITS);

  typedef logic [FLOPOCO_W-1:0]    flopoco_t;
  typedef logic [FP_ID_W-1:0]      id_t;
  typedef logic [FP_WB_UNIT_W-1:0] fp_wb_unit_t;

  // Writeback payload for the default configuration.
  typedef struct packed {
    flopoco_t    rd;
    id_t         id;
    fp_wb_unit_t unit;
  } fp_wb_packet_t;

endpackage

// File: rtl/fp_wb_arbiter_rr_priority_select.sv
// Combinational round-robin selector: first request at or after the pointer.
module rr_priority_select
  import fp_wb_arbiter_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]              i_req,
  input  logic [idx_width(N)-1:0]   i_ptr,
  input  logic                      i_en,
  output logic [N-1:0]              o_gnt_c,
  output logic [idx_width(N)-1:0]   o_idx_c,
  output logic                      o_any_c
);

  localparam int unsigned W = idx_width(N);

  logic        w_found;
  logic [W-1:0] w_idx;

  // Rotating search starting at the pointer; the first hit wins.
  always_comb begin
    int unsigned j;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(i_ptr) + k) % N;
      if (!w_found && i_req[j]) begin
        w_found = 1'b1;
        w_idx   = W'(j);
      end
    end
  end

  // Grant only when the consumer can take a result.
  always_comb begin
    o_gnt_c = '0;
    o_any_c = i_en && w_found;
    o_idx_c = w_idx;
    for (int unsigned i = 0; i < N; i++) begin
      if (o_any_c && (w_idx == W'(i))) o_gnt_c[i] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP writeback arbiter: round-robin accept of unit results into one output stage.
module fp_wb_arbiter
  import fp_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_UNITS = FP_WB_UNITS,
  parameter int unsigned DATA_W    = FLOPOCO_W,
  parameter int unsigned ID_W      = FP_ID_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_UNITS-1:0]             unit_done,
  input  logic [NUM_UNITS*DATA_W-1:0]      unit_rd,
  input  logic [NUM_UNITS*ID_W-1:0]        unit_id,
  output logic [NUM_UNITS-1:0]             unit_ack,
  output logic                             wb_valid,
  input  logic                             wb_ready,
  output logic [DATA_W-1:0]                wb_rd,
  output logic [ID_W-1:0]                  wb_id,
  output logic [idx_width(NUM_UNITS)-1:0]  wb_unit
);

  localparam int unsigned UNIT_W = idx_width(NUM_UNITS);

  typedef struct packed {
    logic [DATA_W-1:0] rd;
    logic [ID_W-1:0]   id;
    logic [UNIT_W-1:0] unit;
  } wb_pkt_t;

  logic                 r_valid;
  wb_pkt_t              r_pkt;
  logic [UNIT_W-1:0]    r_ptr;

  logic                 w_load_en;
  logic [NUM_UNITS-1:0] w_gnt;
  logic [UNIT_W-1:0]    w_idx;
  logic                 w_any;
  logic [UNIT_W-1:0]    w_ptr_nxt;
  wb_pkt_t              w_sel;

  assign w_load_en = !r_valid || wb_ready;

  rr_priority_select #(.N(NUM_UNITS)) u_sel (
    .i_req   (unit_done),
    .i_ptr   (r_ptr),
    .i_en    (w_load_en),
    .o_gnt_c (w_gnt),
    .o_idx_c (w_idx),
    .o_any_c (w_any)
  );

  // Acks are suppressed while reset is held so nothing is lost across reset.
  assign unit_ack = rst_n ? w_gnt : '0;

  // Next pointer sits just past the winner, wrapping at the last unit.
  assign w_ptr_nxt = (w_idx == UNIT_W'(NUM_UNITS - 1)) ? '0 : w_idx + UNIT_W'(1);

  // Mux the winning unit's payload into the output stage format.
  always_comb begin
    w_sel      = '0;
    w_sel.unit = w_idx;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      if (w_idx == UNIT_W'(i)) begin
        w_sel.rd = unit_rd[i*DATA_W +: DATA_W];
        w_sel.id = unit_id[i*ID_W +: ID_W];
      end
    end
  end

  // Output stage and round-robin pointer; reload and consume may share an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pkt   <= '0;
      r_ptr   <= '0;
    end else if (w_any) begin
      r_valid <= 1'b1;
      r_pkt   <= w_sel;
      r_ptr   <= w_ptr_nxt;
    end else if (r_valid && wb_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign wb_valid = r_valid;
  assign wb_rd    = r_pkt.rd;
  assign wb_id    = r_pkt.id;
  assign wb_unit  = r_pkt.unit;

  // A stalled output must hold its contents.
  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (r_valid && !wb_ready) |=> (r_valid && $stable(r_pkt)));

  // At most one ack, and only to a unit presenting a result.
  a_ack_legal: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(unit_ack) && ((unit_ack & ~unit_done) == '0));

endmodule

// File: doc/fp_wb_arbiter.md
Name: fp_wb_arbiter

Overview:
- Writeback-side responder for the FP execution units: consumes the unit-side writeback handshake (done / rd / id, answered with ack) from up to NUM_UNITS FP units, e.g. div/sqrt, FMA and convert.
- Selects at most one finished result per cycle with round-robin priority and acks it in the same cycle.
- Registers the selected result into a single valid/ready output stage that drives the FP register-file write and ID-retire logic.

Parameters:
- NUM_UNITS, 3, number of FP units arbitrated (≥1).
- DATA_W, 34, result width (FloPoCo single-precision format: 2 exception + 1 sign + 8 exponent + 23 fraction).
- ID_W, 3, instruction ID width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- unit_done  input  NUM_UNITS  per-unit result valid; unit holds it with stable rd/id until acked.
- unit_rd  input  NUM_UNITS*DATA_W  per-unit result data, unit i at bits [i*DATA_W +: DATA_W].
- unit_id  input  NUM_UNITS*ID_W  per-unit instruction ID, packed like unit_rd.
- unit_ack  output  NUM_UNITS  one-hot-or-zero accept strobe, combinational.
- wb_valid  output  1  output stage holds a result.
- wb_ready  input  1  downstream consumes the output stage this cycle.
- wb_rd  output  DATA_W  registered result data.
- wb_id  output  ID_W  registered instruction ID.
- wb_unit  output  max(1,clog2(NUM_UNITS))  index of the source unit.

Behaviour:
- Reset (async assert, sync deassert by the environment):
  - wb_valid=0, wb_rd=0, wb_id=0, wb_unit=0.
  - rr_ptr=0.
  - unit_ack=0 while rst_n=0.
- Load enable: load_en = !wb_valid || wb_ready.
- Grant:
  - The first i with unit_done[i]=1, searching i = rr_ptr, rr_ptr+1, … mod NUM_UNITS.
  - unit_ack[i]=1 only when load_en=1 and i is that winner; otherwise all acks are 0.
  - Never ack a unit whose done=0. Never more than one ack per cycle.
- On a grant edge:
  - wb_rd, wb_id and wb_unit load from the winner; wb_valid<=1.
  - rr_ptr <= (winner+1) mod NUM_UNITS, wrapping from NUM_UNITS-1 to 0.
- No grant, and wb_valid && wb_ready: wb_valid<=0; data registers hold their values; rr_ptr unchanged.
- wb_valid && !wb_ready:
  - All registers hold and acks are 0.
  - Units stall, which back-pressures their internal pipelines.
- Simultaneous consume and grant: the output stage reloads in the same edge. This gives full throughput of 1 result/cycle with no bubble.
- Latency: done seen at cycle t with load_en -> ack at t -> wb_valid at t+1.
- Fairness: a continuously-done unit waits at most NUM_UNITS-1 grants.
- NUM_UNITS=1: rr_ptr is constant 0, wb_unit=0.
- Reset mid-transfer: any pending output is discarded. A unit acked in the reset cycle is not counted, because ack is forced to 0 under reset.
- Output data is stable while wb_valid && !wb_ready (check with an assertion).

Decomposition:
- cva5_types gets fp_wb_packet_t {rd: flopoco_t, id: id_t, unit index}, so the output stage is one struct register.
- FP_WB_UNITS constant goes in cva5_config.
- Sub-module rr_priority_select (parameter N):
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant, encoded index, any_grant.
  - Purely combinational; the pointer register lives in fp_wb_arbiter.

Test Plan:
- Reset with unit_done=3'b111 held -> unit_ack=0, wb_valid=0. First cycle after deassert: ack=3'b001. Next cycle: wb_valid=1, wb_unit=0.
- done=3'b111 held, each unit re-presents after ack, wb_ready=1 -> grant order unit 0,1,2,0,1,2; one wb_valid per cycle with no gaps; wb_id matches the source.
- Unit 1 only: rd=34'h0_3F80_0000, id=5 -> ack=3'b010 same cycle. Next cycle: wb_rd=34'h0_3F80_0000, wb_id=5, wb_unit=1. rr_ptr then 2.
- wb_ready=0 for 4 cycles with wb_valid=1 and done=3'b101 -> ack=0 throughout, wb_rd/wb_id stable. When wb_ready=1: ack goes to the unit next in round-robin order and the output reloads in that edge.
- rr_ptr=2, done=3'b011 -> wrap-around grants unit 0, then rr_ptr=1.
- Assert rst_n low while wb_valid=1 and wb_ready=0 -> wb_valid drops immediately (async). Units still show done; after deassert their results are re-granted and none is lost.
